// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Sequencer for the polynomial evaluator S = (A*X + B)*X + C.
// It drives the mux selects, the ALU operation and the register loads of an
// external datapath. Evaluation uses Horner's scheme as the chain
// LOAD -> MUL1 -> ADD1 -> MUL2 -> ADD2 -> DONE.
//
// This is a Moore machine. Every control output is a pure function of the
// current state. Each output is registered and updated on the same edge that
// changes the state, so the outputs never glitch.
//
// Ports
//   clk       in   1  single clock, rising edge
//   rst       in   1  synchronous, active-high reset
//   start     in   1  request an evaluation (accepted only in IDLE)
//   overflow  in   1  ALU overflow for the operation selected this cycle
//   LX        out  1  load X register
//   LS        out  1  load S (result) register
//   LH        out  1  load H register (never used by this sequence)
//   H         out  1  ALU operation (ALU_ADD / ALU_MUL)
//   M0        out  2  operand select: 00 zero, 01 A, 10 B, 11 C
//   M1        out  2  ALU B side: 00 M0 out, 01 Reg_X, 10 Reg_S, 11 Reg_H
//   M2        out  2  ALU A side: 00 Reg_X, 01 M0 out, 10 Reg_S, 11 Reg_H
//   busy      out  1  high in every state except IDLE
//   done      out  1  single-cycle pulse, result register valid
//   error     out  1  sticky: last evaluation aborted on overflow
// -----------------------------------------------------------------------------
module control_unit #(
   parameter logic ALU_ADD = 1'b0,
   parameter logic ALU_MUL = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       overflow,
   output logic       LX,
   output logic       LS,
   output logic       LH,
   output logic       H,
   output logic [1:0] M0,
   output logic [1:0] M1,
   output logic [1:0] M2,
   output logic       busy,
   output logic       done,
   output logic       error
);

   // Operand select codes (M0)
   localparam logic [1:0] M0_ZERO = 2'b00;
   localparam logic [1:0] M0_A    = 2'b01;
   localparam logic [1:0] M0_B    = 2'b10;
   localparam logic [1:0] M0_C    = 2'b11;

   // ALU B-side select codes (M1)
   localparam logic [1:0] M1_M0   = 2'b00;
   localparam logic [1:0] M1_X    = 2'b01;

   // ALU A-side select codes (M2)
   localparam logic [1:0] M2_X    = 2'b00;
   localparam logic [1:0] M2_M0   = 2'b01;
   localparam logic [1:0] M2_S    = 2'b10;

   // Encoding 3'b111 is unused and falls back to IDLE.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_MUL1 = 3'd2,
      S_ADD1 = 3'd3,
      S_MUL2 = 3'd4,
      S_ADD2 = 3'd5,
      S_DONE = 3'd6
   } state_t;

   typedef struct packed {
      logic       lx;
      logic       ls;
      logic       lh;
      logic       h;
      logic [1:0] m0;
      logic [1:0] m1;
      logic [1:0] m2;
      logic       busy;
      logic       done;
   } ctrl_t;

   state_t r_state;
   ctrl_t  r_ctrl;
   logic   r_error;

   // Control word for a given state. Fields not listed keep their IDLE
   // values: no loads, all selects 00, ALU adding.
   function automatic ctrl_t ctrl_of(input state_t s);
      ctrl_t c;
      c      = '0;
      c.h    = ALU_ADD;
      c.m0   = M0_ZERO;
      c.m1   = M1_M0;
      c.m2   = M2_X;
      c.busy = (s != S_IDLE);
      case (s)
         S_LOAD: begin
            c.lx = 1'b1;
         end
         S_MUL1: begin           // S = A * X
            c.ls = 1'b1;
            c.h  = ALU_MUL;
            c.m0 = M0_A;
            c.m2 = M2_M0;
            c.m1 = M1_X;
         end
         S_ADD1: begin           // S = S + B
            c.ls = 1'b1;
            c.h  = ALU_ADD;
            c.m0 = M0_B;
            c.m2 = M2_S;
            c.m1 = M1_M0;
         end
         S_MUL2: begin           // S = S * X
            c.ls = 1'b1;
            c.h  = ALU_MUL;
            c.m0 = M0_ZERO;
            c.m2 = M2_S;
            c.m1 = M1_X;
         end
         S_ADD2: begin           // S = S + C
            c.ls = 1'b1;
            c.h  = ALU_ADD;
            c.m0 = M0_C;
            c.m2 = M2_S;
            c.m1 = M1_M0;
         end
         S_DONE: begin
            c.done = 1'b1;
         end
         default: begin
            c.busy = 1'b0;
         end
      endcase
      return c;
   endfunction

   // State register, registered control word and sticky error.
   // In a compute state an overflow aborts straight to DONE. The LS
   // write of that cycle has already been issued, so the datapath still
   // captures the overflowed value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ctrl  <= ctrl_of(S_IDLE);
         r_error <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_LOAD;
                  r_ctrl  <= ctrl_of(S_LOAD);
                  r_error <= 1'b0;
               end else begin
                  r_state <= S_IDLE;
                  r_ctrl  <= ctrl_of(S_IDLE);
               end
            end
            S_LOAD: begin
               r_state <= S_MUL1;
               r_ctrl  <= ctrl_of(S_MUL1);
            end
            S_MUL1: begin
               if (overflow) begin
                  r_state <= S_DONE;
                  r_ctrl  <= ctrl_of(S_DONE);
                  r_error <= 1'b1;
               end else begin
                  r_state <= S_ADD1;
                  r_ctrl  <= ctrl_of(S_ADD1);
               end
            end
            S_ADD1: begin
               if (overflow) begin
                  r_state <= S_DONE;
                  r_ctrl  <= ctrl_of(S_DONE);
                  r_error <= 1'b1;
               end else begin
                  r_state <= S_MUL2;
                  r_ctrl  <= ctrl_of(S_MUL2);
               end
            end
            S_MUL2: begin
               if (overflow) begin
                  r_state <= S_DONE;
                  r_ctrl  <= ctrl_of(S_DONE);
                  r_error <= 1'b1;
               end else begin
                  r_state <= S_ADD2;
                  r_ctrl  <= ctrl_of(S_ADD2);
               end
            end
            S_ADD2: begin
               // Overflow or not, the next state is DONE. Only error differs.
               r_state <= S_DONE;
               r_ctrl  <= ctrl_of(S_DONE);
               if (overflow) begin
                  r_error <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_ctrl  <= ctrl_of(S_IDLE);
            end
            default: begin
               r_state <= S_IDLE;
               r_ctrl  <= ctrl_of(S_IDLE);
            end
         endcase
      end
   end

   assign LX    = r_ctrl.lx;
   assign LS    = r_ctrl.ls;
   assign LH    = r_ctrl.lh;
   assign H     = r_ctrl.h;
   assign M0    = r_ctrl.m0;
   assign M1    = r_ctrl.m1;
   assign M2    = r_ctrl.m2;
   assign busy  = r_ctrl.busy;
   assign done  = r_ctrl.done;
   assign error = r_error;

endmodule
